// File: rtl/npu_addertree_pkg.sv
// npu_addertree_pkg: shared helpers for the pipelined adder tree.
//   clog2        - ceiling log2, used to size the tree depth
//   level_count  - operands left after a given number of pairwise levels
//   sat_max/min  - signed saturation limits for an accumulator width
//   `ADDERTREE_SUM_W(in_w, n_in) - width of the fully reduced tree sum
`ifndef NPU_ADDERTREE_PKG_SV
`define NPU_ADDERTREE_PKG_SV

`define ADDERTREE_SUM_W(in_w, n_in) ((in_w) + npu_addertree_pkg::clog2(n_in))

package npu_addertree_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Each level halves the operand count, an odd leftover passing through.
  function automatic int level_count(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic longint sat_max(input int acc_w);
    return (longint'(1) <<< (acc_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int acc_w);
    return -(longint'(1) <<< (acc_w - 1));
  endfunction

endpackage

`endif

// File: rtl/addertree_level.sv
// addertree_level: one registered pairwise reduction level.
//   COUNT operands of WIDTH bits in, (COUNT+1)/2 operands of WIDTH+1 bits out.
//   Pairs are sign-extended by one bit and added; an odd last operand is
//   sign-extended and passed through. Data and the valid/first/last sideband
//   are captured only while en is high, so a stall freezes bubbles too.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   en                   pipeline advance
//   in_valid/first/last  sideband from the previous stage
//   in_data              packed signed operands, operand k at [k*WIDTH +: WIDTH]
//   out_valid/first/last registered sideband
//   out_data             packed signed reduced operands
module addertree_level #(
  parameter int COUNT = 9,
  parameter int WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  en,
  input  logic                                  in_valid,
  input  logic                                  in_first,
  input  logic                                  in_last,
  input  logic [COUNT*WIDTH-1:0]                in_data,
  output logic                                  out_valid,
  output logic                                  out_first,
  output logic                                  out_last,
  output logic [((COUNT+1)/2)*(WIDTH+1)-1:0]    out_data
);

  localparam int OUT_COUNT = (COUNT + 1) / 2;
  localparam int OUT_W     = WIDTH + 1;

  logic [OUT_COUNT*OUT_W-1:0] sum;

  for (genvar j = 0; j < OUT_COUNT; j++) begin : g_pair
    logic [WIDTH-1:0] a;
    assign a = in_data[2*j*WIDTH +: WIDTH];
    if (2*j + 1 < COUNT) begin : g_add
      logic [WIDTH-1:0] b;
      assign b = in_data[(2*j+1)*WIDTH +: WIDTH];
      assign sum[j*OUT_W +: OUT_W] = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    end else begin : g_pass
      assign sum[j*OUT_W +: OUT_W] = {a[WIDTH-1], a};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_first <= in_first;
      out_last  <= in_last;
      out_data  <= sum;
    end
  end

endmodule

// File: rtl/addertree_pipe_acc.sv
// addertree_pipe_acc: pipelined signed adder tree with a framed accumulator.
//   N_IN signed operands per beat are reduced over L = clog2(N_IN) registered
//   levels, then summed across the beats of a group (in_first..in_last).
//   A beat accepted in one cycle updates the accumulator L+1 advancing
//   cycles later.
// Handshake: a beat transfers when in_valid && in_ready; a result transfers
//   when out_valid && out_ready. The whole pipe advances together unless a
//   result is held (out_valid && !out_ready), so in_ready is that advance.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid, in_ready, in_data  input beat, operand k at [k*IN_W +: IN_W]
//   in_first, in_last            group framing
//   out_valid, out_ready         result handshake
//   out_data                     signed group sum (ACC_W)
//   out_ovf                      group overflowed ACC_W at some add
// Build option: define ADDERTREE_SATURATE_EN to clamp on overflow instead
//   of wrapping.
module addertree_pipe_acc
  import npu_addertree_pkg::*;
#(
  parameter int N_IN  = 9,
  parameter int IN_W  = 16,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_ovf
);

  localparam int L     = clog2(N_IN);
  localparam int SUM_W = `ADDERTREE_SUM_W(IN_W, N_IN);

  logic advance;
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  for (genvar i = 1; i <= L; i++) begin : g_lvl
    localparam int CNT_IN  = level_count(N_IN, i - 1);
    localparam int CNT_OUT = level_count(N_IN, i);
    localparam int W_IN    = IN_W + i - 1;
    logic [CNT_OUT*(W_IN+1)-1:0] data;
    logic valid;
    logic first;
    logic last;
    if (i == 1) begin : g_head
      addertree_level #(.COUNT(CNT_IN), .WIDTH(W_IN)) u_level (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (advance),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (valid),
        .out_first (first),
        .out_last  (last),
        .out_data  (data)
      );
    end else begin : g_body
      addertree_level #(.COUNT(CNT_IN), .WIDTH(W_IN)) u_level (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (advance),
        .in_valid  (g_lvl[i-1].valid),
        .in_first  (g_lvl[i-1].first),
        .in_last   (g_lvl[i-1].last),
        .in_data   (g_lvl[i-1].data),
        .out_valid (valid),
        .out_first (first),
        .out_last  (last),
        .out_data  (data)
      );
    end
  end

  logic signed [SUM_W-1:0] tree_sum;
  logic                    tree_valid;
  logic                    tree_first;
  logic                    tree_last;
  assign tree_sum   = g_lvl[L].data;
  assign tree_valid = g_lvl[L].valid;
  assign tree_first = g_lvl[L].first;
  assign tree_last  = g_lvl[L].last;

  logic signed [ACC_W-1:0] acc;
  logic                    sticky;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] raw;
  logic signed [ACC_W-1:0] acc_next;
  logic                    add_ovf;
  logic                    sticky_next;

`ifdef ADDERTREE_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));
`endif

  always_comb begin
    sum_ext = ACC_W'(tree_sum);
    // A first beat starts from zero and drops any unfinished group's state.
    base    = tree_first ? '0 : acc;
    raw     = base + sum_ext;
    // Signed overflow: like-signed operands producing an opposite-signed sum.
    add_ovf = (base[ACC_W-1] == sum_ext[ACC_W-1]) && (raw[ACC_W-1] != base[ACC_W-1]);
    sticky_next = (tree_first ? 1'b0 : sticky) | add_ovf;
`ifdef ADDERTREE_SATURATE_EN
    acc_next = add_ovf ? (sum_ext[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw;
`else
    acc_next = raw;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      // Advancing with out_valid high means the result was just taken.
      if (out_valid) out_valid <= 1'b0;
      if (tree_valid) begin
        if (tree_last) begin
          out_valid <= 1'b1;
          out_data  <= acc_next;
          out_ovf   <= sticky_next;
          acc       <= '0;
          sticky    <= 1'b0;
        end else begin
          acc       <= acc_next;
          sticky    <= sticky_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_addertree_pipe_acc.sv
module tb_addertree_pipe_acc;

  localparam int N_IN  = 9;
  localparam int IN_W  = 16;
  localparam int ACC_W = 20;
  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

  logic                 clk;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN*IN_W-1:0] in_data;
  logic                 in_first;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_data;
  logic                 out_ovf;

  addertree_pipe_acc #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [ACC_W:0] exp_q[$];  // {ovf, data}
  longint m_acc    = 0;
  bit     m_sticky = 0;

  bit b2b_mode = 0;
  int b2b_n    = 0;
  int last_pop = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [N_IN*IN_W-1:0] fill(input int v);
    logic [N_IN*IN_W-1:0] d;
    for (int k = 0; k < N_IN; k++) d[k*IN_W +: IN_W] = IN_W'(v);
    return d;
  endfunction

  function automatic logic [N_IN*IN_W-1:0] ramp();
    logic [N_IN*IN_W-1:0] d;
    for (int k = 0; k < N_IN; k++) d[k*IN_W +: IN_W] = IN_W'(k);
    return d;
  endfunction

  function automatic logic [N_IN*IN_W-1:0] rand_beat();
    logic [N_IN*IN_W-1:0] d;
    for (int k = 0; k < N_IN; k++) d[k*IN_W +: IN_W] = IN_W'($urandom_range(0, 65535));
    return d;
  endfunction

  function automatic longint wrap_acc(input longint r);
    longint span;
    longint m;
    span = longint'(1) <<< ACC_W;
    m = r % span;
    if (m < 0) m += span;
    if (m > MAXV) m -= span;
    return m;
  endfunction

  // Reference model: exact sum in wide arithmetic, then wrap or clamp.
  task automatic model_beat(input logic [N_IN*IN_W-1:0] d, input bit first, input bit last);
    longint s;
    longint r;
    bit     st;
    logic [ACC_W-1:0] rd;
    s = 0;
    for (int k = 0; k < N_IN; k++) s += longint'($signed(d[k*IN_W +: IN_W]));
    r  = (first ? 0 : m_acc) + s;
    st = first ? 1'b0 : m_sticky;
    if (r > MAXV || r < MINV) begin
      st = 1'b1;
`ifdef ADDERTREE_SATURATE_EN
      r = (r > MAXV) ? MAXV : MINV;
`else
      r = wrap_acc(r);
`endif
    end
    if (last) begin
      rd = r[ACC_W-1:0];
      exp_q.push_back({st, rd});
      m_acc    = 0;
      m_sticky = 1'b0;
    end else begin
      m_acc    = r;
      m_sticky = st;
    end
  endtask

  // driver
  task automatic send_beat(input logic [N_IN*IN_W-1:0] d, input bit first, input bit last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = first;
    in_last  = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    if (ok) model_beat(d, first, last);
    else check_eq("accept_timeout", in_ready, 1);
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("drain_queue", exp_q.size(), 0);
  endtask

  // scoreboard monitor: a result presented with out_ready is consumed
  always @(negedge clk) begin
    logic [ACC_W:0] e;
    cycle++;
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", $signed(out_data), $signed(e[ACC_W-1:0]));
        check_eq("out_ovf", out_ovf, e[ACC_W]);
      end
      if (b2b_mode) begin
        if (b2b_n > 0) check_eq("b2b_gap", cycle - last_pop, 1);
        b2b_n++;
        last_pop = cycle;
      end
    end
  end

  bit rand_done;
  int lat;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rand_done = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_ovf", out_ovf, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single beat: latency and value
    send_beat(fill(1), 1'b1, 1'b1);
    wait_out(lat);
    check_eq("latency", lat, 5);
    check_eq("single_data", $signed(out_data), 9);
    drain();

    // three-beat group
    send_beat(fill(100), 1'b1, 1'b0);
    send_beat(fill(-50), 1'b0, 1'b0);
    send_beat(ramp(), 1'b0, 1'b1);
    wait_out(lat);
    check_eq("group3_data", $signed(out_data), 486);
    drain();

    // group without first after a completed group starts from zero
    send_beat(fill(1), 1'b0, 1'b1);
    drain();

    // backpressure
    out_ready = 1'b0;
    send_beat(fill(3), 1'b1, 1'b1);
    send_beat(fill(-2), 1'b1, 1'b1);
    send_beat(ramp(), 1'b1, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    fork
      send_beat(fill(5), 1'b1, 1'b1);
      begin
        repeat (6) @(negedge clk);
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_out_valid", out_valid, 1);
        check_eq("stall_out_data", $signed(out_data), 27);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // back-to-back single-beat groups
    b2b_mode = 1'b1;
    b2b_n    = 0;
    for (int i = 0; i < 8; i++) send_beat(fill((i % 2) ? -1 : 1), 1'b1, 1'b1);
    drain();
    b2b_mode = 1'b0;
    check_eq("b2b_results", b2b_n, 8);

    // overflow
    for (int i = 0; i < 4; i++) send_beat(fill(32'h7FFF), i == 0, i == 3);
    wait_out(lat);
`ifdef ADDERTREE_SATURATE_EN
    check_eq("ovf_data", $signed(out_data), 524287);
`else
    check_eq("ovf_data", $signed(out_data), 131036);
`endif
    check_eq("ovf_flag", out_ovf, 1);
    drain();

    // random groups with random downstream readiness
    fork
      begin
        for (int g = 0; g < 15; g++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) send_beat(rand_beat(), b == 0, b == len - 1);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // reset mid-group discards the partial group
    send_beat(fill(7), 1'b1, 1'b0);
    send_beat(fill(7), 1'b0, 1'b0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    m_acc    = 0;
    m_sticky = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_data", out_data, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    send_beat(fill(2), 1'b1, 1'b1);
    wait_out(lat);
    check_eq("post_rst_data", $signed(out_data), 18);
    check_eq("post_rst_ovf", out_ovf, 0);
    drain();

    check_eq("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", cycle, 0);
    $fatal(1, "timeout");
  end

endmodule
